// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding and sizing helper for the FIR tap chain
package fir_pkg;

  // Sequencer states; the numeric values are visible on ov_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Width of the shared coefficient index / flush counter.
  function automatic int cnt_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// rtl/fir_coef_regfile.sv - write-indexed coefficient register file with flat read bus
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low clear of all words
//   i_we            write strobe
//   iv_waddr        word index to write
//   iv_wdata        word to write
//   ov_rdata        all words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
module fir_coef_regfile #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_we,
  input  logic [ADDR_WIDTH-1:0]          iv_waddr,
  input  logic [DATA_WIDTH-1:0]          iv_wdata,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_rdata
);

  logic [DATA_WIDTH-1:0] words_q [NUM_TAPS];

  // Decode by compare so a non-power-of-two NUM_TAPS never indexes past the array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        words_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (i_we && (iv_waddr == ADDR_WIDTH'(k))) begin
          words_q[k] <= iv_wdata;
        end
      end
    end
  end

  always_comb begin
    ov_rdata = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      ov_rdata[k*DATA_WIDTH +: DATA_WIDTH] = words_q[k];
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR tap chain sequencer: coefficient load, flush, sample streaming
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_load_start                   pulse to begin a coefficient load
//   i_coef_valid/iv_coef/o_coef_ready  coefficient handshake
//   i_in_valid/iv_sample/o_in_ready    sample handshake
//   o_out_valid/i_out_ready/ov_result/o_result_ovf  registered filter output
//   o_tap_en, ov_tap_din, ov_weights   drive to the tap chain
//   iv_chain_sum, iv_prod_ovf, iv_sum_ovf  returns from the tap chain
//   i_clr_status, o_ovf_sticky     sticky overflow status
//   ov_state                       current state (debug)
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_load_start,
  input  logic                           i_coef_valid,
  input  logic [DATA_WIDTH-1:0]          iv_coef,
  output logic                           o_coef_ready,
  input  logic                           i_in_valid,
  input  logic [DATA_WIDTH-1:0]          iv_sample,
  output logic                           o_in_ready,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [DATA_WIDTH-1:0]          ov_result,
  output logic                           o_result_ovf,
  output logic                           o_tap_en,
  output logic [DATA_WIDTH-1:0]          ov_tap_din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
  input  logic [NUM_TAPS-1:0]            iv_prod_ovf,
  input  logic [NUM_TAPS-1:0]            iv_sum_ovf,
  input  logic                           i_clr_status,
  output logic                           o_ovf_sticky,
  output logic [1:0]                     ov_state
);

  localparam int CW = cnt_width(NUM_TAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TAPS - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;       // coefficient index in LOAD, flush count in FLUSH
  logic                  coef_we;
  logic                  accept;
  logic                  ovf_now;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  result_ovf_q;
  logic                  sticky_q;

  fir_coef_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .ADDR_WIDTH (CW)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (coef_we),
    .iv_waddr (idx_q),
    .iv_wdata (iv_coef),
    .ov_rdata (ov_weights)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    o_coef_ready = 1'b0;
    o_in_ready   = 1'b0;
    o_tap_en     = 1'b0;
    ov_tap_din   = '0;
    coef_we      = 1'b0;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        o_coef_ready = 1'b1;
        if (i_coef_valid) begin
          coef_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FLUSH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        // Shift zeros through every tap so stale samples never reach a result.
        o_tap_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_RUN: begin
        o_in_ready = !out_valid_q || i_out_ready;
        accept     = i_in_valid && o_in_ready;
        if (accept) begin
          o_tap_en   = 1'b1;
          ov_tap_din = iv_sample;
        end
        // A sample accepted in the same cycle still completes into the output register.
        if (i_load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign ovf_now = |(iv_prod_ovf | iv_sum_ovf);

  // The output register is independent of state so a pending result survives a reload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      result_q     <= iv_chain_sum;
      result_ovf_q <= ovf_now;
    end else if (i_out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Setting takes priority over a same-cycle clear so no overflow is ever lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= 1'b0;
    end else if (accept && ovf_now) begin
      sticky_q <= 1'b1;
    end else if (i_clr_status) begin
      sticky_q <= 1'b0;
    end
  end

  assign o_out_valid  = out_valid_q;
  assign ov_result    = result_q;
  assign o_result_ovf = result_ovf_q;
  assign o_ovf_sticky = sticky_q;
  assign ov_state     = state_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - directed self-checking bench for fir_ctrl with a behavioral tap chain
module tb_fir_ctrl;

  localparam int DW = 8;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, coef_valid, coef_ready;
  logic [DW-1:0] coef;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] sample, result, tap_din;
  logic          result_ovf, tap_en, clr_status, ovf_sticky;
  logic [NT*DW-1:0] weights;
  logic [DW-1:0] chain_sum;
  logic [NT-1:0] prod_ovf, sum_ovf;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_start (load_start),
    .i_coef_valid (coef_valid),
    .iv_coef      (coef),
    .o_coef_ready (coef_ready),
    .i_in_valid   (in_valid),
    .iv_sample    (sample),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .ov_result    (result),
    .o_result_ovf (result_ovf),
    .o_tap_en     (tap_en),
    .ov_tap_din   (tap_din),
    .ov_weights   (weights),
    .iv_chain_sum (chain_sum),
    .iv_prod_ovf  (prod_ovf),
    .iv_sum_ovf   (sum_ovf),
    .i_clr_status (clr_status),
    .o_ovf_sticky (ovf_sticky),
    .ov_state     (state)
  );

  // Behavioral direct-form chain: current input plus NT-1 delayed samples.
  logic [DW-1:0] dl [NT-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NT-1; k++) dl[k] <= '0;
    end else if (tap_en) begin
      dl[0] <= tap_din;
      for (int k = 1; k < NT-1; k++) dl[k] <= dl[k-1];
    end
  end
  assign chain_sum = DW'(weights[0*DW +: DW] * tap_din + weights[1*DW +: DW] * dl[0]
                       + weights[2*DW +: DW] * dl[1] + weights[3*DW +: DW] * dl[2]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs(input logic [DW-1:0] c0, c1, c2, c3, input bit gap);
    logic [DW-1:0] c [NT];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < NT; i++) begin
      coef_valid = 1'b1;
      coef = c[i];
      tick();
      if (gap && i == 1) begin
        coef_valid = 1'b0;
        tick();
      end
    end
    coef_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_start = 0; coef_valid = 0; coef = '0; in_valid = 0; sample = '0;
    out_ready = 0; prod_ovf = '0; sum_ovf = '0; clr_status = 0;
    tick();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (weights !== 32'h0) begin n_bad++; $display("FAIL reset_weights: got %0h expected 0", weights); end
    n_cmp++; if ({out_valid, result, result_ovf, ovf_sticky} !== '0) begin n_bad++; $display("FAIL reset_outreg: got %0h expected 0", {out_valid, result, result_ovf, ovf_sticky}); end
    n_cmp++; if ({coef_ready, in_ready, tap_en, tap_din} !== '0) begin n_bad++; $display("FAIL reset_comb: got %0h expected 0", {coef_ready, in_ready, tap_en, tap_din}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int flush_n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++; if ({state, coef_ready, in_ready} !== 4'b0110) begin n_bad++; $display("FAIL load_enter: got %b expected 0110", {state, coef_ready, in_ready}); end
    coef_valid = 1; coef = 8'd1; tick();
    coef = 8'd2; tick();
    coef_valid = 0; coef = 8'd9; tick();
    n_cmp++; if (weights !== 32'h00000201) begin n_bad++; $display("FAIL load_gap: got %0h expected 00000201", weights); end
    coef_valid = 1; coef = 8'd3; tick();
    coef = 8'd4; tick();
    coef_valid = 0;
    n_cmp++; if (weights !== 32'h04030201) begin n_bad++; $display("FAIL load_weights: got %0h expected 04030201", weights); end
    flush_n = 0;
    for (int i = 0; i < 10 && state != 2'd3; i++) begin
      if (state == 2'd2 && tap_en && tap_din == '0 && !in_ready) flush_n++;
      tick();
    end
    n_cmp++; if (flush_n !== 4) begin n_bad++; $display("FAIL flush_cycles: got %0d expected 4", flush_n); end
    n_cmp++; if ({state, in_ready, tap_en} !== 4'b1110) begin n_bad++; $display("FAIL run_ready: got %b expected 1110", {state, in_ready, tap_en}); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] smp [5];
    logic [DW-1:0] exp_r [5];
    smp[0] = 1; smp[1] = 0; smp[2] = 0; smp[3] = 0; smp[4] = 0;
    exp_r[0] = 1; exp_r[1] = 2; exp_r[2] = 3; exp_r[3] = 4; exp_r[4] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sample = smp[i];
      #1;
      n_cmp++; if ({tap_en, tap_din} !== {1'b1, smp[i]}) begin n_bad++; $display("FAIL stream_din[%0d]: got %0h expected %0h", i, {tap_en, tap_din}, {1'b1, smp[i]}); end
      tick();
      n_cmp++; if ({out_valid, result} !== {1'b1, exp_r[i]}) begin n_bad++; $display("FAIL stream_result[%0d]: got %0h expected %0h", i, {out_valid, result}, {1'b1, exp_r[i]}); end
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (tap_en !== 1'b0) begin n_bad++; $display("FAIL stream_idle_en: got %b expected 0", tap_en); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    sample = 8'd5;
    tick();
    n_cmp++; if ({out_valid, result} !== {1'b1, 8'd5}) begin n_bad++; $display("FAIL bp_first: got %0h expected 105", {out_valid, result}); end
    sample = 8'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({in_ready, tap_en, out_valid, result} !== {1'b0, 1'b0, 1'b1, 8'd5}) begin n_bad++; $display("FAIL bp_hold[%0d]: got %0h expected 105", i, {in_ready, tap_en, out_valid, result}); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if ({in_ready, tap_en} !== 2'b11) begin n_bad++; $display("FAIL bp_release: got %b expected 11", {in_ready, tap_en}); end
    tick();
    n_cmp++; if ({out_valid, result} !== {1'b1, 8'd17}) begin n_bad++; $display("FAIL bp_second: got %0h expected 111", {out_valid, result}); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; sample = 8'd0; sum_ovf = 4'b0100;
    tick();
    n_cmp++; if ({result, result_ovf, ovf_sticky} !== {8'd29, 2'b11}) begin n_bad++; $display("FAIL ovf_set: got %0h expected 77", {result, result_ovf, ovf_sticky}); end
    sum_ovf = '0;
    tick();
    n_cmp++; if ({result, result_ovf, ovf_sticky} !== {8'd41, 2'b01}) begin n_bad++; $display("FAIL ovf_next: got %0h expected a5", {result, result_ovf, ovf_sticky}); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL ovf_hold: got %b expected 1", ovf_sticky); end
    clr_status = 1'b1;
    tick();
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", ovf_sticky); end
    in_valid = 1'b1; prod_ovf = 4'b0010;
    tick();
    n_cmp++; if ({result, result_ovf, ovf_sticky} !== {8'd28, 2'b11}) begin n_bad++; $display("FAIL ovf_set_wins: got %0h expected 73", {result, result_ovf, ovf_sticky}); end
    in_valid = 1'b0; prod_ovf = '0; clr_status = 1'b0;
    tick();
  endtask

  task automatic test_reload();
    int flush_n;
    out_ready = 1'b0;
    in_valid = 1'b1; sample = 8'd3; load_start = 1'b1;
    #1;
    n_cmp++; if (tap_en !== 1'b1) begin n_bad++; $display("FAIL reload_accept_en: got %b expected 1", tap_en); end
    tick();
    in_valid = 1'b0; load_start = 1'b0;
    n_cmp++; if ({state, out_valid, result} !== {2'd1, 1'b1, 8'd3}) begin n_bad++; $display("FAIL reload_result: got %0h expected 303", {state, out_valid, result}); end
    for (int i = 0; i < NT; i++) begin
      coef_valid = 1'b1; coef = 8'd5;
      tick();
    end
    coef_valid = 1'b0;
    n_cmp++; if (weights !== 32'h05050505) begin n_bad++; $display("FAIL reload_weights: got %0h expected 05050505", weights); end
    flush_n = 0;
    for (int i = 0; i < 10 && state != 2'd3; i++) begin
      if (state == 2'd2 && tap_en && tap_din == '0) flush_n++;
      tick();
    end
    n_cmp++; if (flush_n !== 4) begin n_bad++; $display("FAIL reload_flush: got %0d expected 4", flush_n); end
    n_cmp++; if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 8'd3}) begin n_bad++; $display("FAIL reload_pending: got %0h expected 103", {in_ready, out_valid, result}); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL reload_drain: got %b expected 10", {in_ready, out_valid}); end
  endtask

  task automatic test_async_reset();
    load_coefs(8'd6, 8'd7, 8'd8, 8'd9, 1'b0);
    tick();
    tick();
    n_cmp++; if ({state, tap_en, weights} !== {2'd2, 1'b1, 32'h09080706}) begin n_bad++; $display("FAIL areset_pre: got %0h expected 509080706", {state, tap_en, weights}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({state, tap_en, coef_ready, in_ready, out_valid, weights} !== '0) begin n_bad++; $display("FAIL areset_now: got %0h expected 0", {state, tap_en, coef_ready, in_ready, out_valid, weights}); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({state, weights, tap_en} !== '0) begin n_bad++; $display("FAIL areset_after: got %0h expected 0", {state, weights, tap_en}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_overflow();
    test_reload();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
